// File: rtl/sonar_seq_pkg.sv
// sonar_seq_pkg: shared state encoding and default parameters for the sonar vector sequencer.
package sonar_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LAUNCH, RUN, DRAIN, FINISH} state_t;
  localparam int MAX_PARALLEL_DEF = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1000;
  localparam int VEC_W_DEF = 16;
endpackage

// File: rtl/sonar_seq_watchdog.sv
// sonar_seq_watchdog: saturating per-vector cycle counter that flags expiry at TIMEOUT_CYCLES-1.
module sonar_seq_watchdog
  import sonar_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt;
  assign expired = cnt == LAST;
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/sonar_vector_sequencer.sv
// sonar_vector_sequencer: fetches per-vector thread masks, launches threads and guards each vector with a watchdog.
// Optional SONAR_SEQ_STOP_ON_ERROR_EN ends the run after the first vector that latches an error.
module sonar_vector_sequencer
  import sonar_seq_pkg::*;
#(
  parameter int MAX_PARALLEL = MAX_PARALLEL_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int VEC_W = VEC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VEC_W-1:0]        vector_count,
  input  logic                    mask_valid,
  output logic                    mask_ready,
  input  logic [MAX_PARALLEL-1:0] thread_mask,
  output logic [MAX_PARALLEL-1:0] thread_start,
  input  logic [MAX_PARALLEL-1:0] thread_done,
  input  logic [MAX_PARALLEL-1:0] thread_error,
  output logic                    thread_abort,
  output logic [VEC_W-1:0]        vector_idx,
  output logic                    busy,
  output logic                    run_done,
  output logic                    pass,
  output logic [MAX_PARALLEL-1:0] error_latched
);
  state_t state, state_n;
  logic [MAX_PARALLEL-1:0] mask;
  logic [VEC_W-1:0] count;
  logic run_done_q, pass_q, expired, complete, last, stop;
  sonar_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk(clk),
    .rst(rst),
    .clear(state == LAUNCH),
    .enable(state == RUN),
    .expired(expired)
  );
  assign complete = (thread_done & mask) == mask;
  assign last = vector_idx == count - VEC_W'(1);
`ifdef SONAR_SEQ_STOP_ON_ERROR_EN
  assign stop = last || (|error_latched);
`else
  assign stop = last;
`endif
  assign mask_ready = state == FETCH;
  assign thread_start = state == LAUNCH ? mask : '0;
  // completion beats a simultaneous expiry; reset suppresses any abort
  assign thread_abort = state == RUN && expired && !complete && !rst;
  assign busy = !(state == IDLE || state == FINISH);
  assign run_done = run_done_q || state == FINISH;
  assign pass = state == FINISH ? ~|error_latched : pass_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (vector_count == '0 ? FINISH : FETCH) : IDLE;
      FETCH:   state_n = mask_valid ? (|thread_mask ? LAUNCH : DRAIN) : FETCH;
      LAUNCH:  state_n = RUN;
      RUN:     state_n = complete || expired ? DRAIN : RUN;
      DRAIN:   state_n = stop ? FINISH : FETCH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mask <= '0;
      count <= '0;
      vector_idx <= '0;
      error_latched <= '0;
      run_done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        count <= vector_count;
        vector_idx <= '0;
        error_latched <= '0;
        run_done_q <= 1'b0;
        pass_q <= 1'b0;
      end
      if (state == FETCH && mask_valid) mask <= thread_mask;
      if (state == RUN) error_latched <= error_latched | (thread_error & mask) | (thread_abort ? mask & ~thread_done : '0);
      if (state == DRAIN && !stop) vector_idx <= vector_idx + VEC_W'(1);
      if (state == FINISH) begin
        run_done_q <= 1'b1;
        pass_q <= ~|error_latched;
      end
    end
  end
endmodule

// File: tb/tb_sonar_vector_sequencer.sv
// tb_sonar_vector_sequencer: directed scenarios with hand-computed expectations for the vector sequencer.
module tb_sonar_vector_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] vector_count = '0;
  logic mask_valid = 1'b0;
  logic mask_ready;
  logic [3:0] thread_mask = '0;
  logic [3:0] thread_start;
  logic [3:0] thread_done = '0;
  logic [3:0] thread_error = '0;
  logic thread_abort;
  logic [15:0] vector_idx;
  logic busy, run_done, pass;
  logic [3:0] error_latched;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int abort_cnt = 0;
  int abort_cyc = 0;
  int launch_cyc = 0;
  int hs_cnt = 0;
  logic [3:0] starts[$];

  sonar_vector_sequencer #(.MAX_PARALLEL(4), .TIMEOUT_CYCLES(8), .VEC_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .vector_count(vector_count),
    .mask_valid(mask_valid), .mask_ready(mask_ready), .thread_mask(thread_mask),
    .thread_start(thread_start), .thread_done(thread_done), .thread_error(thread_error),
    .thread_abort(thread_abort), .vector_idx(vector_idx), .busy(busy),
    .run_done(run_done), .pass(pass), .error_latched(error_latched)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    cyc++;
    if (|thread_start) begin
      starts.push_back(thread_start);
      launch_cyc = cyc;
    end
    if (thread_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    if (mask_ready && mask_valid) hs_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_mon();
    starts.delete();
    abort_cnt = 0;
    hs_cnt = 0;
  endtask

  task automatic pulse_start(input logic [15:0] vc);
    vector_count = vc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed_mask(input logic [3:0] m);
    int n = 0;
    while (!mask_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (mask_ready !== 1'b1) begin
      failures++;
      $display("FAIL feed_mask_wait: mask_ready=%b required 1", mask_ready);
    end
    mask_valid = 1'b1;
    thread_mask = m;
    tick();
    mask_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (run_done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (run_done !== 1'b1) begin
      failures++;
      $display("FAIL run_done_wait: run_done=%b required 1", run_done);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, run_done, pass, mask_ready, thread_abort} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: busy/run_done/pass/mask_ready/abort=%b required 00000", {busy, run_done, pass, mask_ready, thread_abort});
    end
    checks++;
    if ({thread_start, error_latched, vector_idx} !== 24'h0) begin
      failures++;
      $display("FAIL reset_vectors: start=%b err=%b idx=%0d required 0", thread_start, error_latched, vector_idx);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    clear_mon();
    pulse_start(16'd2);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: busy=%b required 1", busy);
    end
    feed_mask(4'b0011);
    tick();
    tick();
    thread_done = 4'b0011;
    tick();
    thread_done = 4'b0000;
    checks++;
    if (vector_idx !== 16'd0) begin
      failures++;
      $display("FAIL basic_idx0: vector_idx=%0d required 0", vector_idx);
    end
    feed_mask(4'b1000);
    checks++;
    if (vector_idx !== 16'd1) begin
      failures++;
      $display("FAIL basic_idx1: vector_idx=%0d required 1", vector_idx);
    end
    tick();
    thread_done = 4'b1000;
    tick();
    thread_done = 4'b0000;
    wait_done();
    checks++;
    if ({run_done, pass, busy} !== 3'b110) begin
      failures++;
      $display("FAIL basic_result: run_done/pass/busy=%b required 110", {run_done, pass, busy});
    end
    checks++;
    if (starts.size() != 2 || starts[0] !== 4'b0011 || starts[1] !== 4'b1000) begin
      failures++;
      $display("FAIL basic_starts: count=%0d required 2 with 0011 then 1000", starts.size());
    end
    checks++;
    if (vector_idx !== 16'd1 || abort_cnt != 0) begin
      failures++;
      $display("FAIL basic_end: vector_idx=%0d aborts=%0d required 1 and 0", vector_idx, abort_cnt);
    end
  endtask

  task automatic test_timeout();
    clear_mon();
    thread_done = 4'b0001;
    pulse_start(16'd1);
    feed_mask(4'b0101);
    wait_done();
    thread_done = 4'b0000;
    checks++;
    if (abort_cnt != 1) begin
      failures++;
      $display("FAIL timeout_abort_count: aborts=%0d required 1", abort_cnt);
    end
    checks++;
    if (abort_cyc - launch_cyc != 8) begin
      failures++;
      $display("FAIL timeout_abort_time: cycles after launch=%0d required 8", abort_cyc - launch_cyc);
    end
    checks++;
    if (error_latched !== 4'b0100 || pass !== 1'b0) begin
      failures++;
      $display("FAIL timeout_result: err=%b pass=%b required 0100 and 0", error_latched, pass);
    end
  endtask

  task automatic test_zero_mask_expiry_edge();
    clear_mon();
    pulse_start(16'd2);
    feed_mask(4'b0000);
    feed_mask(4'b0100);
    repeat (8) tick();
    thread_done = 4'b0100;
    tick();
    thread_done = 4'b0000;
    wait_done();
    checks++;
    if (abort_cnt != 0 || pass !== 1'b1 || error_latched !== 4'b0000) begin
      failures++;
      $display("FAIL edge_result: aborts=%0d pass=%b err=%b required 0, 1, 0000", abort_cnt, pass, error_latched);
    end
    checks++;
    if (starts.size() != 1 || starts[0] !== 4'b0100) begin
      failures++;
      $display("FAIL zero_mask_starts: count=%0d required 1 with 0100", starts.size());
    end
    checks++;
    if (hs_cnt != 2 || vector_idx !== 16'd1) begin
      failures++;
      $display("FAIL zero_mask_count: handshakes=%0d idx=%0d required 2 and 1", hs_cnt, vector_idx);
    end
  endtask

  task automatic test_error();
    clear_mon();
    pulse_start(16'd3);
    feed_mask(4'b0011);
    tick();
    thread_error = 4'b0010;
    tick();
    thread_error = 4'b0000;
    thread_done = 4'b0011;
    tick();
    thread_done = 4'b0000;
    checks++;
    if (error_latched !== 4'b0010) begin
      failures++;
      $display("FAIL error_latch: err=%b required 0010", error_latched);
    end
`ifndef SONAR_SEQ_STOP_ON_ERROR_EN
    for (int v = 1; v < 3; v++) begin
      feed_mask(4'b0011);
      tick();
      thread_done = 4'b0011;
      tick();
      thread_done = 4'b0000;
    end
`endif
    wait_done();
    checks++;
    if (pass !== 1'b0 || error_latched !== 4'b0010) begin
      failures++;
      $display("FAIL error_result: pass=%b err=%b required 0 and 0010", pass, error_latched);
    end
`ifdef SONAR_SEQ_STOP_ON_ERROR_EN
    checks++;
    if (hs_cnt != 1 || vector_idx !== 16'd0) begin
      failures++;
      $display("FAIL error_stop: handshakes=%0d idx=%0d required 1 and 0", hs_cnt, vector_idx);
    end
`else
    checks++;
    if (hs_cnt != 3 || vector_idx !== 16'd2) begin
      failures++;
      $display("FAIL error_all_vectors: handshakes=%0d idx=%0d required 3 and 2", hs_cnt, vector_idx);
    end
`endif
  endtask

  task automatic test_empty_run();
    clear_mon();
    pulse_start(16'd0);
    checks++;
    if ({run_done, pass, busy} !== 3'b110) begin
      failures++;
      $display("FAIL empty_finish: run_done/pass/busy=%b required 110", {run_done, pass, busy});
    end
    tick();
    checks++;
    if (hs_cnt != 0 || error_latched !== 4'b0000 || run_done !== 1'b1) begin
      failures++;
      $display("FAIL empty_after: handshakes=%0d err=%b run_done=%b required 0, 0000, 1", hs_cnt, error_latched, run_done);
    end
  endtask

  task automatic test_back_to_back_start();
    clear_mon();
    pulse_start(16'd1);
    vector_count = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (mask_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_start: mask_ready=%b busy=%b required 1 and 1", mask_ready, busy);
    end
    feed_mask(4'b0001);
    tick();
    thread_done = 4'b0001;
    tick();
    thread_done = 4'b0000;
    wait_done();
    checks++;
    if (vector_idx !== 16'd0 || hs_cnt != 1 || pass !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_result: idx=%0d handshakes=%0d pass=%b required 0, 1, 1", vector_idx, hs_cnt, pass);
    end
  endtask

  task automatic test_reset_mid_run();
    clear_mon();
    pulse_start(16'd2);
    feed_mask(4'b1111);
    tick();
    thread_error = 4'b1000;
    tick();
    thread_error = 4'b0000;
    checks++;
    if (error_latched !== 4'b1000) begin
      failures++;
      $display("FAIL mid_run_err: err=%b required 1000", error_latched);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, run_done, pass, mask_ready, thread_start, error_latched} !== 12'h0 || vector_idx !== 16'd0) begin
      failures++;
      $display("FAIL mid_run_reset: busy=%b done=%b pass=%b rdy=%b start=%b err=%b idx=%0d required all 0",
               busy, run_done, pass, mask_ready, thread_start, error_latched, vector_idx);
    end
    repeat (12) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (abort_cnt != 0 || starts.size() != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_run_abort: aborts=%0d starts=%0d busy=%b required 0, 1, 0", abort_cnt, starts.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_zero_mask_expiry_edge();
    test_error();
    test_empty_run();
    test_back_to_back_start();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
